// File: rtl/uart_pkg.sv
// Shared UART types and sample-point constants for the 16x oversampled receive path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_t;

   localparam logic [3:0] SAMPLE_LO   = 4'd7;
   localparam logic [3:0] SAMPLE_MID  = 4'd8;
   localparam logic [3:0] SAMPLE_HI   = 4'd9;
   localparam logic [3:0] SAMPLE_LAST = 4'd15;
   localparam int         DATA_BITS   = 8;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Serial line in, ready/valid byte out plus status pulses; master is the receiver side.
interface uart_rx_oversampled_if;
   logic       rx;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   modport master (
      input  rx, rx_ready,
      output rx_data, rx_valid, frame_err, overrun, busy
   );

   modport slave (
      output rx, rx_ready,
      input  rx_data, rx_valid, frame_err, overrun, busy
   );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk pulse every CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks.
// Free-running, no backpressure; shareable with the transmit path.
module uart_baud_tick #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 19200,
   parameter int OVERSAMPLE = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_tick
);
   localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   if (DIV < 2) begin : g_div_check
      $error("uart_baud_tick: divider must be at least 2");
   end

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst)              r_cnt <= '0;
      else if (r_cnt == LAST) r_cnt <= '0;
      else                    r_cnt <= r_cnt + 1'b1;
   end

   assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver, 16x oversampled with 3-sample mid-bit majority vote; byte valid 1 clk after stop vote.
// Holding register waits for rx_ready; a good byte arriving while it is full is dropped with an overrun pulse.
module uart_rx_oversampled
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 19200,
   parameter int OVERSAMPLE = 16
) (
   input logic                  i_clk,
   input logic                  i_rst,
   uart_rx_oversampled_if.master bus
);
   logic                 w_tick;
   logic                 r_rx_meta, r_rx_s;
   rx_state_t            r_state, w_state_nxt;
   logic [3:0]           r_scnt;
   logic [2:0]           r_bitcnt;
   logic                 r_s7, r_s8;
   logic [DATA_BITS-1:0] r_shift;
   logic [7:0]           r_rx_data;
   logic                 r_rx_valid, r_frame_err, r_overrun;
   logic                 w_vote, w_at_vote, w_at_last;
   logic                 w_busy, w_shift_en, w_deliver, w_ferr;

   uart_baud_tick #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE),
      .OVERSAMPLE(OVERSAMPLE)
   ) u_tick (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .o_tick(w_tick)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= bus.rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   // Third vote sample is the live synchronised line on the SAMPLE_HI tick.
   assign w_vote    = maj3(r_s7, r_s8, r_rx_s);
   assign w_at_vote = w_tick && (r_scnt == SAMPLE_HI);
   assign w_at_last = w_tick && (r_scnt == SAMPLE_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:      if (w_tick && !r_rx_s) w_state_nxt = START;
         START: begin
            if (w_at_vote && w_vote) w_state_nxt = IDLE;
            else if (w_at_last)      w_state_nxt = DATA;
         end
         DATA:      if (w_at_last && r_bitcnt == 3'(DATA_BITS - 1)) w_state_nxt = STOP;
         STOP:      if (w_at_vote) w_state_nxt = w_vote ? IDLE : WAIT_HIGH;
         WAIT_HIGH: if (r_rx_s) w_state_nxt = IDLE;
         default:   w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_busy     = 1'b1;
      w_shift_en = 1'b0;
      w_deliver  = 1'b0;
      w_ferr     = 1'b0;
      case (r_state)
         IDLE: w_busy = 1'b0;
         DATA: w_shift_en = w_at_vote;
         STOP: begin
            w_deliver = w_at_vote && w_vote;
            w_ferr    = w_at_vote && !w_vote;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_scnt      <= '0;
         r_bitcnt    <= '0;
         r_s7        <= 1'b1;
         r_s8        <= 1'b1;
         r_shift     <= '0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_ferr;
         r_overrun   <= 1'b0;

         if (r_state == IDLE) r_scnt <= '0;
         else if (w_tick)     r_scnt <= r_scnt + 1'b1;

         if (r_state != DATA) r_bitcnt <= '0;
         else if (w_at_last)  r_bitcnt <= r_bitcnt + 1'b1;

         if (w_tick && r_scnt == SAMPLE_LO)  r_s7 <= r_rx_s;
         if (w_tick && r_scnt == SAMPLE_MID) r_s8 <= r_rx_s;
         if (w_shift_en) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};

         // A byte may load in the same cycle the consumer drains the previous one.
         if (w_deliver) begin
            if (!r_rx_valid || bus.rx_ready) begin
               r_rx_data  <= r_shift;
               r_rx_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_rx_valid && bus.rx_ready) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   assign bus.rx_data   = r_rx_data;
   assign bus.rx_valid  = r_rx_valid;
   assign bus.frame_err = r_frame_err;
   assign bus.overrun   = r_overrun;
   assign bus.busy      = w_busy;
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: DIV=10, 160 clk per bit, bytes checked through an expected-byte queue.
module tb_uart_rx_oversampled;
   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_rx_oversampled_if u_if ();

   uart_rx_oversampled #(
      .CLK_FREQ  (1600000),
      .BAUD_RATE (10000),
      .OVERSAMPLE(16)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (u_if)
   );

   always #5 clk = ~clk;

   int         checks    = 0;
   int         errors    = 0;
   int         cyc       = 0;
   int         vld_rises = 0;
   int         ferr_cnt  = 0;
   int         ovr_cnt   = 0;
   logic       vld_prev  = 1'b0;
   logic [7:0] exp_q [$];

   // Mirrors the tick phase: a tick edge leaves cyc at a multiple of 10.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (u_if.rx_valid && !vld_prev) vld_rises++;
         if (u_if.frame_err) ferr_cnt++;
         if (u_if.overrun)   ovr_cnt++;
         if (u_if.rx_valid && u_if.rx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL sb_underflow observed=0x%0h expected=no byte", u_if.rx_data);
            end else begin
               chk("sb_byte", {24'd0, u_if.rx_data}, {24'd0, exp_q.pop_front()});
            end
         end
      end
      vld_prev <= u_if.rx_valid;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Line falls just after an edge with cyc%10==7, so rx_s is low on the next tick edge.
   task automatic align();
      int guard;
      guard = 0;
      while ((cyc % 10) != 7 && guard < 20) begin
         step(1);
         guard++;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_k, input bit chk_lat);
      for (int k = 0; k < 1600; k++) begin
         int   bi;
         logic lvl;
         bi = k / 160;
         if (bi == 0)      lvl = 1'b0;
         else if (bi <= 8) lvl = b[bi-1];
         else              lvl = stop;
         if (k == glitch_k) lvl = ~lvl;
         u_if.rx = lvl;
         step(1);
         if (chk_lat && k == 1541) begin
            chk("valid_before_stop_vote", {31'd0, u_if.rx_valid}, 32'd0);
            chk("busy_before_stop_vote", {31'd0, u_if.busy}, 32'd1);
         end
         if (chk_lat && k == 1542) begin
            chk("valid_after_stop_vote", {31'd0, u_if.rx_valid}, 32'd1);
            chk("busy_after_stop_vote", {31'd0, u_if.busy}, 32'd0);
         end
      end
   endtask

   initial begin
      int cnt;
      u_if.rx       = 1'b1;
      u_if.rx_ready = 1'b0;
      rst           = 1'b1;
      step(5);
      chk("rst_rx_data", {24'd0, u_if.rx_data}, 32'd0);
      chk("rst_rx_valid", {31'd0, u_if.rx_valid}, 32'd0);
      chk("rst_frame_err", {31'd0, u_if.frame_err}, 32'd0);
      chk("rst_overrun", {31'd0, u_if.overrun}, 32'd0);
      chk("rst_busy", {31'd0, u_if.busy}, 32'd0);
      rst = 1'b0;
      step(20);

      // Test 1: clean frame, consumer always ready
      u_if.rx_ready = 1'b1;
      exp_q.push_back(8'hA5);
      align();
      send_frame(8'hA5, 1'b1, -1, 1'b1);
      step(20);
      chk("t1_valid_rises", vld_rises, 32'd1);
      chk("t1_no_frame_err", ferr_cnt, 32'd0);

      // Test 2: 40-clk low glitch is rejected at the start-bit vote
      align();
      u_if.rx = 1'b0;
      step(40);
      chk("t2_start_entered", {31'd0, u_if.busy}, 32'd1);
      u_if.rx = 1'b1;
      step(62);
      chk("t2_busy_before_vote", {31'd0, u_if.busy}, 32'd1);
      step(1);
      chk("t2_false_start_idle", {31'd0, u_if.busy}, 32'd0);
      step(200);
      chk("t2_no_valid", vld_rises, 32'd1);
      chk("t2_no_frame_err", ferr_cnt, 32'd0);

      // Test 3: low stop bit then a held break
      align();
      send_frame(8'h3C, 1'b0, -1, 1'b0);
      cnt = 0;
      for (int i = 0; i < 480; i++) begin
         step(1);
         if (!u_if.busy) cnt++;
      end
      chk("t3_wait_high_held", cnt, 32'd0);
      chk("t3_one_frame_err", ferr_cnt, 32'd1);
      chk("t3_no_valid", vld_rises, 32'd1);
      u_if.rx = 1'b1;
      step(5);
      chk("t3_idle_after_release", {31'd0, u_if.busy}, 32'd0);
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         step(1);
         if (u_if.busy) cnt++;
      end
      chk("t3_no_retrigger", cnt, 32'd0);

      // Test 4: back-to-back frames with consumer stalled
      u_if.rx_ready = 1'b0;
      exp_q.push_back(8'h11);
      align();
      send_frame(8'h11, 1'b1, -1, 1'b0);
      send_frame(8'h22, 1'b1, -1, 1'b0);
      step(10);
      chk("t4_valid_held", {31'd0, u_if.rx_valid}, 32'd1);
      chk("t4_data_held", {24'd0, u_if.rx_data}, 32'h11);
      chk("t4_one_overrun", ovr_cnt, 32'd1);
      u_if.rx_ready = 1'b1;
      step(1);
      chk("t4_valid_cleared", {31'd0, u_if.rx_valid}, 32'd0);
      chk("t4_data_unchanged", {24'd0, u_if.rx_data}, 32'h11);

      // Test 6: reset in the middle of a 0xFF frame
      step(30);
      align();
      u_if.rx = 1'b0;
      step(160);
      u_if.rx = 1'b1;
      step(540);
      chk("t6_mid_frame_busy", {31'd0, u_if.busy}, 32'd1);
      rst = 1'b1;
      step(1);
      chk("t6_rst_rx_data", {24'd0, u_if.rx_data}, 32'd0);
      chk("t6_rst_rx_valid", {31'd0, u_if.rx_valid}, 32'd0);
      chk("t6_rst_frame_err", {31'd0, u_if.frame_err}, 32'd0);
      chk("t6_rst_overrun", {31'd0, u_if.overrun}, 32'd0);
      chk("t6_rst_busy", {31'd0, u_if.busy}, 32'd0);
      step(2);
      rst = 1'b0;
      step(30);
      exp_q.push_back(8'h5A);
      align();
      send_frame(8'h5A, 1'b1, -1, 1'b0);
      step(20);
      chk("t6_rx_data", {24'd0, u_if.rx_data}, 32'h5A);

      // Test 5: single-clock glitch on each vote sample of data bit 3
      for (int g = 0; g < 3; g++) begin
         exp_q.push_back(8'h00);
         align();
         send_frame(8'h00, 1'b1, 720 + 10 * g, 1'b0);
      end
      step(20);

      chk("end_queue_empty", exp_q.size(), 32'd0);
      chk("end_valid_rises", vld_rises, 32'd6);
      chk("end_frame_errs", ferr_cnt, 32'd1);
      chk("end_overruns", ovr_cnt, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
